// File: rtl/avalon_ifetch_pkg.sv
// Shared types and constants for the Avalon-MM instruction fetch master.
package avalon_ifetch_pkg;

  localparam int         WORD_BYTES = 4;
  localparam logic [3:0] BE_ALL     = 4'b1111;

  typedef enum logic [1:0] {IDLE, REQ, HOLD} ifetch_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } ifetch_entry_t;

endpackage

// File: rtl/ifetch_fifo.sv
// Prefetch FIFO of {pc, instr} entries; flush has priority over push and pop.
module ifetch_fifo
  import avalon_ifetch_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          push,
  input  ifetch_entry_t push_entry,
  input  logic          pop,
  input  logic          flush,
  output ifetch_entry_t head,
  output logic [CNT_W-1:0] count
);

  ifetch_entry_t    mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !flush;
  assign do_pop  = pop && (count != '0) && !flush;
  assign head    = mem[rd_ptr];

  // NOTE: the storage array is deliberately not reset; count alone says which entries are meaningful.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_entry;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  a_no_overfill: assert property (@(posedge clk) disable iff (!reset_n)
    !(push && !flush && (count == CNT_W'(DEPTH))));

endmodule

// File: rtl/avalon_ifetch_master.sv
// Avalon-MM pipelined read master prefetching sequential instruction words for the core.
// Define IFETCH_PERF_EN to add saturating HOLD-cycle and redirect counters.
module avalon_ifetch_master
  import avalon_ifetch_pkg::*;
#(
  parameter int          ADDR_W     = 12,
  parameter logic [31:0] RESET_PC   = 32'h0,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_read,
  output logic [3:0]        avm_byteenable,
  input  logic              avm_waitrequest,
  input  logic [31:0]       avm_readdata,
  input  logic              avm_readdatavalid,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc,
  output logic              instr_valid,
  output logic [31:0]       instr_data,
  output logic [31:0]       instr_pc,
  input  logic              instr_ready
`ifdef IFETCH_PERF_EN
  ,
  output logic [31:0]       perf_stall_cnt,
  output logic [15:0]       perf_flush_cnt
`endif
);

  localparam int             CNT_W   = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W:0] CREDITS = (CNT_W+1)'(FIFO_DEPTH);

  ifetch_state_t    state;
  logic [31:0]      fetch_pc, fetch_pc_next, ret_pc, redir_pc;
  logic [CNT_W-1:0] outstanding, out_next, discard, disc_next;
  logic [CNT_W-1:0] fifo_count, cnt_next;
  logic             stale, accept, rdv, drop, push, pop, credit;
  ifetch_entry_t    push_entry, head;

  assign redir_pc       = redirect_pc & ~32'h3;
  assign accept         = avm_read & ~avm_waitrequest;
  // Returns with nothing outstanding are leftovers from before a reset.
  assign rdv            = avm_readdatavalid & (outstanding != '0);
  assign drop           = rdv & (discard != '0);
  assign push           = rdv & ~drop;
  assign instr_valid    = (fifo_count != '0);
  assign pop            = instr_valid & instr_ready;
  assign push_entry     = '{pc: ret_pc, instr: avm_readdata};
  assign instr_pc       = head.pc;
  assign instr_data     = head.instr;
  assign avm_byteenable = BE_ALL;

  // NOTE: each variable gets a value on every path through always_comb, so no latch is inferred.
  always_comb begin
    out_next = outstanding + CNT_W'(accept) - CNT_W'(rdv);
    cnt_next = redirect_valid ? '0 : fifo_count + CNT_W'(push) - CNT_W'(pop);
    // On redirect everything still in flight after this edge is stale, including a same-cycle accept.
    disc_next = redirect_valid ? out_next
                               : discard - CNT_W'(drop) + CNT_W'(accept & stale);
    if (redirect_valid)      fetch_pc_next = redir_pc;
    else if (accept & ~stale) fetch_pc_next = fetch_pc + 32'(WORD_BYTES);
    else                     fetch_pc_next = fetch_pc;
    credit = ({1'b0, cnt_next} + {1'b0, out_next}) < CREDITS;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      avm_read    <= 1'b0;
      avm_address <= RESET_PC[ADDR_W-1:0];
      fetch_pc    <= RESET_PC;
      ret_pc      <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
      stale       <= 1'b0;
    end else begin
      outstanding <= out_next;
      discard     <= disc_next;
      fetch_pc    <= fetch_pc_next;
      if (redirect_valid) ret_pc <= redir_pc;
      else if (push)      ret_pc <= ret_pc + 32'(WORD_BYTES);
      case (state)
        IDLE: begin
          if (credit) begin
            state       <= REQ;
            avm_read    <= 1'b1;
            avm_address <= fetch_pc_next[ADDR_W-1:0];
          end
        end
        REQ, HOLD: begin
          if (accept) begin
            stale <= 1'b0;
            if (credit) begin
              state       <= REQ;
              avm_address <= fetch_pc_next[ADDR_W-1:0];
            end else begin
              state    <= IDLE;
              avm_read <= 1'b0;
            end
          end else begin
            // The stalled request must stay on the bus unchanged, even if the core redirects.
            state <= HOLD;
            if (redirect_valid) stale <= 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          avm_read <= 1'b0;
        end
      endcase
    end
  end

  ifetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk        (clk),
    .reset_n    (reset_n),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .flush      (redirect_valid),
    .head       (head),
    .count      (fifo_count)
  );

`ifdef IFETCH_PERF_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_stall_cnt <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if ((state == HOLD) && (perf_stall_cnt != '1)) perf_stall_cnt <= perf_stall_cnt + 32'd1;
      if (redirect_valid && (perf_flush_cnt != '1))  perf_flush_cnt <= perf_flush_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_avalon_ifetch_master.sv
// Self-checking bench: in-order variable-latency slave model plus an expected-PC instruction stream.
module tb_avalon_ifetch_master;

  localparam int ADDR_W = 12;
  localparam int DEPTH  = 4;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [ADDR_W-1:0] avm_address;
  logic              avm_read;
  logic [3:0]        avm_byteenable;
  logic              avm_waitrequest;
  logic [31:0]       avm_readdata;
  logic              avm_readdatavalid;
  logic              redirect_valid;
  logic [31:0]       redirect_pc;
  logic              instr_valid;
  logic [31:0]       instr_data;
  logic [31:0]       instr_pc;
  logic              instr_ready;
`ifdef IFETCH_PERF_EN
  logic [31:0]       perf_stall_cnt;
  logic [15:0]       perf_flush_cnt;
`endif

  avalon_ifetch_master #(.ADDR_W(ADDR_W), .RESET_PC(32'h0), .FIFO_DEPTH(DEPTH)) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .avm_address       (avm_address),
    .avm_read          (avm_read),
    .avm_byteenable    (avm_byteenable),
    .avm_waitrequest   (avm_waitrequest),
    .avm_readdata      (avm_readdata),
    .avm_readdatavalid (avm_readdatavalid),
    .redirect_valid    (redirect_valid),
    .redirect_pc       (redirect_pc),
    .instr_valid       (instr_valid),
    .instr_data        (instr_data),
    .instr_pc          (instr_pc),
    .instr_ready       (instr_ready)
`ifdef IFETCH_PERF_EN
    ,
    .perf_stall_cnt    (perf_stall_cnt),
    .perf_flush_cnt    (perf_flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    int                due;
  } slv_t;

  slv_t              q[$];
  int                checks = 0;
  int                failures = 0;
  int                cyc = 0;
  int                last_due = 0;
  int                lat_min = 1;
  int                lat_max = 1;
  logic [31:0]       exp_pc;
  logic              cons, acc, hold_prev, redir_prev;
  logic [31:0]       cons_pc, cons_data, cons_exp;
  logic [ADDR_W-1:0] acc_addr, held_addr;

  function automatic logic [31:0] mem_word(input logic [ADDR_W-1:0] a);
    return 32'hAB5C_3000 ^ {a, 8'h00, a};
  endfunction

  // One clock: drive inputs at the falling edge, account for what the next rising edge does.
  task automatic tick(input logic wr, input logic rdy, input logic redir,
                      input logic [31:0] rpc, input logic late);
    logic              pre_read;
    logic [ADDR_W-1:0] pre_addr;
    int                d;
    pre_read = avm_read;
    pre_addr = avm_address;
    if (late) begin
      avm_readdatavalid = 1'b1;
      avm_readdata      = 32'hDEAD_BEEF;
    end else if (q.size() > 0 && q[0].due <= cyc) begin
      avm_readdatavalid = 1'b1;
      avm_readdata      = mem_word(q[0].addr);
      q.delete(0);
    end else begin
      avm_readdatavalid = 1'b0;
      avm_readdata      = $urandom;
    end
    avm_waitrequest = wr;
    instr_ready     = rdy;
    redirect_valid  = redir;
    redirect_pc     = rpc;
    acc      = pre_read & ~wr;
    acc_addr = pre_addr;
    if (acc) begin
      d = cyc + int'($urandom_range(lat_min, lat_max));
      if (d < last_due) d = last_due;
      last_due = d;
      q.push_back('{addr: pre_addr, due: d});
    end
    cons      = instr_valid & rdy;
    cons_pc   = instr_pc;
    cons_data = instr_data;
    cons_exp  = exp_pc;
    if (cons)  exp_pc = exp_pc + 32'd4;
    if (redir) exp_pc = rpc & ~32'h3;
    hold_prev  = pre_read & wr;
    held_addr  = pre_addr;
    redir_prev = redir;
    @(negedge clk);
    cyc++;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    avm_waitrequest = 1'b0; avm_readdatavalid = 1'b0; avm_readdata = '0;
    redirect_valid = 1'b0; redirect_pc = '0; instr_ready = 1'b0;
    q.delete(); last_due = 0; exp_pc = 32'h0;
    hold_prev = 1'b0; redir_prev = 1'b0; cons = 1'b0; acc = 1'b0;
    repeat (2) @(negedge clk);
    cyc += 2;
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (avm_read !== 1'b0) begin failures++; $display("FAIL reset_read got=%b exp=0", avm_read); end
    checks++; if (avm_address !== '0) begin failures++; $display("FAIL reset_addr got=%h exp=000", avm_address); end
    checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", instr_valid); end
    checks++; if (avm_byteenable !== 4'hF) begin failures++; $display("FAIL byteenable got=%h exp=f", avm_byteenable); end
    tick(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    checks++;
    if (avm_read !== 1'b1 || avm_address !== '0)
      begin failures++; $display("FAIL first_req got=%b/%h exp=1/000", avm_read, avm_address); end
  endtask

  task automatic test_fill();
    int n_acc = 0;
    int n_cons = 0;
    do_reset(); lat_min = 1; lat_max = 1;
    repeat (20) begin
      tick(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      if (acc) n_acc++;
    end
    checks++; if (n_acc !== DEPTH) begin failures++; $display("FAIL fill_reads got=%0d exp=%0d", n_acc, DEPTH); end
    checks++; if (avm_read !== 1'b0) begin failures++; $display("FAIL fill_read_low got=%b exp=0", avm_read); end
    checks++;
    if (instr_valid !== 1'b1 || instr_pc !== 32'h0)
      begin failures++; $display("FAIL fill_head got=%b/%h exp=1/00000000", instr_valid, instr_pc); end
    repeat (16) begin
      tick(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
      if (cons) begin
        n_cons++; checks++;
        if (cons_pc !== cons_exp || cons_data !== mem_word(cons_exp[ADDR_W-1:0]))
          begin failures++; $display("FAIL fill_stream got=%h/%h exp_pc=%h", cons_pc, cons_data, cons_exp); end
      end
    end
    checks++; if (n_cons < DEPTH) begin failures++; $display("FAIL fill_drain got=%0d exp>=%0d", n_cons, DEPTH); end
  endtask

  task automatic test_waitrequest();
    int guard = 0;
    int n8 = 0;
    do_reset(); lat_min = 1; lat_max = 1;
    while (!(avm_read === 1'b1 && avm_address === 12'h8) && guard < 50) begin
      tick(1'b0, 1'b1, 1'b0, 32'h0, 1'b0); guard++;
    end
    checks++; if (guard >= 50) begin failures++; $display("FAIL wait_find got=timeout exp=addr 008"); end
    for (int i = 0; i < 5; i++) begin
      tick(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
      checks++;
      if (avm_read !== 1'b1 || avm_address !== 12'h8)
        begin failures++; $display("FAIL wait_stable got=%b/%h exp=1/008", avm_read, avm_address); end
    end
    repeat (11) begin
      tick(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
      if (acc && acc_addr == 12'h8) n8++;
      if (cons) begin
        checks++;
        if (cons_pc !== cons_exp || cons_data !== mem_word(cons_exp[ADDR_W-1:0]))
          begin failures++; $display("FAIL wait_stream got=%h/%h exp_pc=%h", cons_pc, cons_data, cons_exp); end
      end
    end
    checks++; if (n8 !== 1) begin failures++; $display("FAIL wait_single got=%0d exp=1", n8); end
  endtask

  task automatic test_redirect_outstanding();
    int guard = 0;
    do_reset(); lat_min = 3; lat_max = 3;
    while (q.size() < 2 && guard < 50) begin tick(1'b0, 1'b1, 1'b0, 32'h0, 1'b0); guard++; end
    checks++; if (guard >= 50) begin failures++; $display("FAIL redir_setup got=timeout exp=2 outstanding"); end
    tick(1'b0, 1'b1, 1'b1, 32'h100, 1'b0);
    checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL redir_flush got=%b exp=0", instr_valid); end
    guard = 0;
    while (instr_valid !== 1'b1 && guard < 30) begin tick(1'b0, 1'b0, 1'b0, 32'h0, 1'b0); guard++; end
    checks++;
    if (instr_valid !== 1'b1 || instr_pc !== 32'h100 || instr_data !== mem_word(12'h100))
      begin failures++; $display("FAIL redir_first got=%b/%h/%h exp=1/00000100/%h", instr_valid, instr_pc, instr_data, mem_word(12'h100)); end
    repeat (8) begin
      tick(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
      if (cons) begin
        checks++;
        if (cons_pc !== cons_exp || cons_data !== mem_word(cons_exp[ADDR_W-1:0]))
          begin failures++; $display("FAIL redir_stream got=%h/%h exp_pc=%h", cons_pc, cons_data, cons_exp); end
      end
    end
  endtask

  task automatic test_redirect_hold();
    int guard = 0;
    do_reset(); lat_min = 1; lat_max = 1;
    while (!(avm_read === 1'b1 && avm_address === 12'h8) && guard < 50) begin
      tick(1'b0, 1'b1, 1'b0, 32'h0, 1'b0); guard++;
    end
    checks++; if (guard >= 50) begin failures++; $display("FAIL hold_find got=timeout exp=addr 008"); end
    tick(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    tick(1'b1, 1'b1, 1'b1, 32'h40, 1'b0);
    checks++;
    if (avm_read !== 1'b1 || avm_address !== 12'h8)
      begin failures++; $display("FAIL hold_redir got=%b/%h exp=1/008", avm_read, avm_address); end
    tick(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    tick(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    checks++;
    if (acc !== 1'b1 || acc_addr !== 12'h8)
      begin failures++; $display("FAIL hold_accept got=%b/%h exp=1/008", acc, acc_addr); end
    checks++;
    if (avm_read !== 1'b1 || avm_address !== 12'h40)
      begin failures++; $display("FAIL hold_next got=%b/%h exp=1/040", avm_read, avm_address); end
    guard = 0;
    while (instr_valid !== 1'b1 && guard < 30) begin tick(1'b0, 1'b0, 1'b0, 32'h0, 1'b0); guard++; end
    checks++;
    if (instr_valid !== 1'b1 || instr_pc !== 32'h40 || instr_data !== mem_word(12'h40))
      begin failures++; $display("FAIL hold_first got=%b/%h/%h exp=1/00000040/%h", instr_valid, instr_pc, instr_data, mem_word(12'h40)); end
  endtask

  task automatic test_wrap();
    int guard = 0;
    logic saw_zero = 1'b0;
    do_reset(); lat_min = 1; lat_max = 1;
    repeat (3) tick(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    tick(1'b0, 1'b1, 1'b1, 32'h103, 1'b0);
    checks++;
    if (avm_read !== 1'b1 || avm_address !== 12'h100)
      begin failures++; $display("FAIL wrap_align got=%b/%h exp=1/100", avm_read, avm_address); end
    while (instr_valid !== 1'b1 && guard < 30) begin tick(1'b0, 1'b0, 1'b0, 32'h0, 1'b0); guard++; end
    checks++;
    if (instr_pc !== 32'h100 || instr_valid !== 1'b1)
      begin failures++; $display("FAIL wrap_first got=%b/%h exp=1/00000100", instr_valid, instr_pc); end
    tick(1'b0, 1'b1, 1'b1, 32'hFFFF_FFF8, 1'b0);
    repeat (14) begin
      tick(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
      if (acc) begin
        checks++;
        if (acc_addr[1:0] !== 2'b00) begin failures++; $display("FAIL wrap_addr_low got=%h exp=aligned", acc_addr); end
      end
      if (cons) begin
        if (cons_pc === 32'h0) saw_zero = 1'b1;
        checks++;
        if (cons_pc !== cons_exp || cons_data !== mem_word(cons_exp[ADDR_W-1:0]))
          begin failures++; $display("FAIL wrap_stream got=%h/%h exp_pc=%h", cons_pc, cons_data, cons_exp); end
      end
    end
    checks++; if (saw_zero !== 1'b1) begin failures++; $display("FAIL wrap_zero got=none exp=pc 00000000"); end
  endtask

  task automatic test_async_reset();
    int guard = 0;
    do_reset(); lat_min = 3; lat_max = 3;
    while (q.size() < 2 && guard < 50) begin tick(1'b0, 1'b0, 1'b0, 32'h0, 1'b0); guard++; end
    reset_n = 1'b0;
    avm_readdatavalid = 1'b0;
    #1;
    checks++;
    if (avm_read !== 1'b0 || instr_valid !== 1'b0 || avm_address !== '0)
      begin failures++; $display("FAIL async_reset got=%b/%b/%h exp=0/0/000", avm_read, instr_valid, avm_address); end
    q.delete(); last_due = 0; exp_pc = 32'h0; hold_prev = 1'b0; redir_prev = 1'b0;
    @(negedge clk);
    cyc++;
    reset_n = 1'b1;
    tick(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    guard = 0;
    while (instr_valid !== 1'b1 && guard < 30) begin tick(1'b0, 1'b0, 1'b0, 32'h0, 1'b0); guard++; end
    checks++;
    if (instr_valid !== 1'b1 || instr_pc !== 32'h0 || instr_data !== mem_word(12'h0))
      begin failures++; $display("FAIL late_rdv got=%b/%h/%h exp=1/00000000/%h", instr_valid, instr_pc, instr_data, mem_word(12'h0)); end
  endtask

  task automatic test_random();
    logic        wr, rdy, rd;
    logic [31:0] rpc;
    do_reset(); lat_min = 1; lat_max = 4;
    for (int i = 0; i < 3000; i++) begin
      wr  = ($urandom_range(0, 3) == 0);
      rdy = ($urandom_range(0, 9) < 7);
      rd  = ($urandom_range(0, 49) == 0);
      rpc = $urandom;
      if ($urandom_range(0, 3) == 0) rpc = 32'hFFFF_FFF0 | (rpc & 32'hF);
      tick(wr, rdy, rd, rpc, 1'b0);
      if (hold_prev) begin
        checks++;
        if (avm_read !== 1'b1 || avm_address !== held_addr)
          begin failures++; $display("FAIL rnd_hold got=%b/%h exp=1/%h", avm_read, avm_address, held_addr); end
      end
      if (redir_prev) begin
        checks++;
        if (instr_valid !== 1'b0) begin failures++; $display("FAIL rnd_flush got=%b exp=0", instr_valid); end
      end
      if (cons) begin
        checks++;
        if (cons_pc !== cons_exp || cons_data !== mem_word(cons_exp[ADDR_W-1:0]))
          begin failures++; $display("FAIL rnd_stream got=%h/%h exp_pc=%h", cons_pc, cons_data, cons_exp); end
      end
      checks++;
      if (q.size() > DEPTH || avm_address[1:0] !== 2'b00)
        begin failures++; $display("FAIL rnd_bus got=%0d/%h exp<=%0d/aligned", q.size(), avm_address, DEPTH); end
    end
  endtask

  initial begin
    reset_n = 1'b0;
    test_reset();
    test_fill();
    test_waitrequest();
    test_redirect_outstanding();
    test_redirect_hold();
    test_wrap();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
